// File: rtl/rq_arb_pkg.sv
// Shared helpers for the round-robin request arbiter family.
package rq_arb_pkg;

    function automatic int unsigned src_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmn_real_mux_onehot.sv
// AND-OR payload multiplexer driven by a one-hot (or all-zero) select vector.
module cmn_real_mux_onehot #(
    parameter int unsigned WIDTH    = 4,
    parameter type         PLD_TYPE = logic
) (
    input  logic [WIDTH-1:0] i_sel,
    input  PLD_TYPE          i_data [WIDTH],
    output PLD_TYPE          o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_sel[i]) begin
                o_data = o_data | i_data[i];
            end
        end
    end

endmodule

// File: rtl/cmn_rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping.
module cmn_rr_pick
    import rq_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM = 4,
    parameter int unsigned SRC_W   = src_width(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [REQ_NUM-1:0] o_gnt,
    output logic [SRC_W-1:0]   o_idx,
    output logic               o_vld
);

    logic [REQ_NUM-1:0]   w_mask;
    logic [2*REQ_NUM-1:0] w_dbl;

    // Low half holds requests at or above the pointer, high half the wrapped copy.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            w_mask[i] = (i >= int'(i_ptr));
        end
        w_dbl = {i_req, i_req & w_mask};
    end

    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        o_gnt = '0;
        for (int k = 0; k < 2 * REQ_NUM; k++) begin
            if (w_dbl[k] && !o_vld) begin
                o_vld = 1'b1;
                o_idx = SRC_W'(k % REQ_NUM);
            end
        end
        if (o_vld) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rq_arbiter_rr.sv
// Round-robin request arbiter with burst lock and a one-deep registered output slot.
module rq_arbiter_rr
    import rq_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM  = 4,
    parameter type         PLD_TYPE = logic,
    parameter bit          LOCK_EN  = 1'b1,
    parameter int unsigned SRC_W    = src_width(REQ_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] a_req_vld,
    output logic [REQ_NUM-1:0] a_req_rdy,
    input  PLD_TYPE            a_req_pld [REQ_NUM],
    input  logic [REQ_NUM-1:0] a_req_last,
    input  logic               out_req_rdy,
    output logic               out_req_vld,
    output PLD_TYPE            out_req_pld,
    output logic [SRC_W-1:0]   out_req_src
);

    logic               r_out_vld;
    PLD_TYPE            r_out_pld;
    logic [SRC_W-1:0]   r_out_src;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic               r_lock_vld;
    logic [SRC_W-1:0]   r_lock_idx;

    logic               w_load_en;
    logic [REQ_NUM-1:0] w_pick_req;
    logic [REQ_NUM-1:0] w_gnt;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic               w_gnt_vld;
    logic               w_accept;
    logic               w_lock_beat;
    logic [SRC_W-1:0]   w_ptr_next;
    PLD_TYPE            w_sel_pld;

    assign w_load_en = !r_out_vld || out_req_rdy;

    // While locked only the owner may compete; everyone else is masked off.
    assign w_pick_req = r_lock_vld ? (a_req_vld & (REQ_NUM'(1) << r_lock_idx)) : a_req_vld;

    cmn_rr_pick #(
        .REQ_NUM (REQ_NUM),
        .SRC_W   (SRC_W)
    ) u_pick (
        .i_req (w_pick_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_vld (w_gnt_vld)
    );

    cmn_real_mux_onehot #(
        .WIDTH    (REQ_NUM),
        .PLD_TYPE (PLD_TYPE)
    ) u_mux (
        .i_sel  (w_gnt),
        .i_data (a_req_pld),
        .o_data (w_sel_pld)
    );

    // Held low during reset so no beat is handshaken while the slot is being cleared.
    assign a_req_rdy   = (w_load_en && rst_n) ? w_gnt : '0;
    assign w_accept    = w_load_en && w_gnt_vld;
    assign w_lock_beat = LOCK_EN && !a_req_last[w_gnt_idx];
    assign w_ptr_next  = (w_gnt_idx == SRC_W'(REQ_NUM - 1)) ? '0 : w_gnt_idx + SRC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_pld <= '0;
            r_out_src <= '0;
        end else if (w_load_en) begin
            r_out_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_out_pld <= w_sel_pld;
                r_out_src <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_accept) begin
            if (w_lock_beat) begin
                r_lock_vld <= 1'b1;
                r_lock_idx <= w_gnt_idx;
            end else begin
                r_lock_vld <= 1'b0;
                r_rr_ptr   <= w_ptr_next;
            end
        end
    end

    assign out_req_vld = r_out_vld;
    assign out_req_pld = r_out_pld;
    assign out_req_src = r_out_src;

    a_rdy_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(a_req_rdy));

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_req_vld && !out_req_rdy) |=> ($stable(out_req_pld) && $stable(out_req_src)));

endmodule

// File: tb/tb_rq_arbiter_rr.sv
// Directed scoreboard bench: expected beats are queued at accept time and checked at the output slot.
module tb_rq_arbiter_rr;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] pld;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a_req_vld;
    logic [3:0] a_req_rdy;
    logic [7:0] a_req_pld [4];
    logic [3:0] a_req_last;
    logic       out_req_rdy;
    logic       out_req_vld;
    logic [7:0] out_req_pld;
    logic [1:0] out_req_src;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   beat   = 0;

    rq_arbiter_rr #(
        .REQ_NUM  (4),
        .PLD_TYPE (logic [7:0]),
        .LOCK_EN  (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_req_vld   (a_req_vld),
        .a_req_rdy   (a_req_rdy),
        .a_req_pld   (a_req_pld),
        .a_req_last  (a_req_last),
        .out_req_rdy (out_req_rdy),
        .out_req_vld (out_req_vld),
        .out_req_pld (out_req_pld),
        .out_req_src (out_req_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic ok, input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        assert (ok) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    endtask

    // One clock cycle: drive inputs, check rdy and the output slot, then update the scoreboard.
    task automatic step(input logic [3:0] vld, input logic [3:0] last, input logic rdy,
                        input int exp_ch, input string tag);
        logic [3:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        a_req_vld   = vld;
        a_req_last  = last;
        out_req_rdy = rdy;
        beat++;
        for (int i = 0; i < 4; i++) begin
            a_req_pld[i] = {i[1:0], beat[5:0]};
        end
        #1;
        exp_rdy = (exp_ch >= 0) ? 4'(1 << exp_ch) : 4'b0000;
        chk(a_req_rdy === exp_rdy, {tag, "_rdy"}, 16'(a_req_rdy), 16'(exp_rdy));
        chk(out_req_vld === (q.size() != 0), {tag, "_vld"}, 16'(out_req_vld),
            16'(q.size() != 0));
        if (q.size() != 0) begin
            e = q[0];
            chk(out_req_src === e.src, {tag, "_src"}, 16'(out_req_src), 16'(e.src));
            chk(out_req_pld === e.pld, {tag, "_pld"}, 16'(out_req_pld), 16'(e.pld));
            if (rdy) void'(q.pop_front());
        end
        if (exp_ch >= 0) begin
            e.src = exp_ch[1:0];
            e.pld = a_req_pld[exp_ch];
            q.push_back(e);
        end
    endtask

    localparam logic [3:0] ALL = 4'b1111;
    localparam logic [3:0] NOL = 4'b1111;

    initial begin
        rst_n       = 1'b0;
        a_req_vld   = '0;
        a_req_last  = '0;
        out_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) a_req_pld[i] = '0;
        repeat (2) @(negedge clk);
        chk(out_req_vld === 1'b0, "rst_vld", 16'(out_req_vld), 16'd0);
        chk(out_req_src === 2'd0, "rst_src", 16'(out_req_src), 16'd0);
        chk(out_req_pld === 8'd0, "rst_pld", 16'(out_req_pld), 16'd0);
        rst_n = 1'b1;

        // Traffic, then asynchronous reset mid-cycle.
        step(ALL, NOL, 1'b1, 0, "pre0");
        step(ALL, NOL, 1'b1, 1, "pre1");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(out_req_vld === 1'b0, "mrst_vld", 16'(out_req_vld), 16'd0);
        chk(out_req_src === 2'd0, "mrst_src", 16'(out_req_src), 16'd0);
        chk(out_req_pld === 8'd0, "mrst_pld", 16'(out_req_pld), 16'd0);
        chk(a_req_rdy === 4'b0, "mrst_rdy", 16'(a_req_rdy), 16'd0);
        q.delete();
        a_req_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fairness after reset: 0,1,2,3,0,1.
        step(ALL, NOL, 1'b1, 0, "rr0");
        step(ALL, NOL, 1'b1, 1, "rr1");
        step(ALL, NOL, 1'b1, 2, "rr2");
        step(ALL, NOL, 1'b1, 3, "rr3");
        step(ALL, NOL, 1'b1, 0, "rr4");
        step(ALL, NOL, 1'b1, 1, "rr5");

        // Backpressure with ch2 valid.
        step(4'b0100, NOL, 1'b1, 2, "bp_load");
        repeat (5) step(4'b0100, NOL, 1'b0, -1, "bp_hold");
        step(4'b0100, NOL, 1'b1, 2, "bp_resume");
        step(4'b0000, NOL, 1'b1, -1, "bp_drain");

        // Lock: ch1 bursts 3 beats while ch0/ch3 compete.
        step(4'b0001, NOL, 1'b1, 0, "lk_pre");
        step(4'b1011, 4'b0000, 1'b1, 1, "lk_b0");
        step(4'b1011, 4'b0000, 1'b1, 1, "lk_b1");
        step(4'b1011, 4'b0010, 1'b1, 1, "lk_b2");
        step(4'b1001, NOL, 1'b1, 3, "lk_next3");
        step(4'b1001, NOL, 1'b1, 0, "lk_next0");

        // Lock stall: owner drops valid, ch0 must stay blocked.
        step(4'b0011, 4'b0000, 1'b1, 1, "st_b0");
        repeat (4) step(4'b0001, 4'b0000, 1'b1, -1, "st_gap");
        step(4'b0011, 4'b0010, 1'b1, 1, "st_last");
        step(4'b0001, NOL, 1'b1, 0, "st_ch0");

        // Wrap with ch3/ch0, then a single requester at full rate.
        step(4'b0100, NOL, 1'b1, 2, "wr_pre");
        step(4'b1001, NOL, 1'b1, 3, "wr3a");
        step(4'b1001, NOL, 1'b1, 0, "wr0a");
        step(4'b1001, NOL, 1'b1, 3, "wr3b");
        step(4'b1001, NOL, 1'b1, 0, "wr0b");
        repeat (5) step(4'b0100, NOL, 1'b1, 2, "single2");
        step(4'b0000, NOL, 1'b1, -1, "end_drain");
        step(4'b0000, NOL, 1'b1, -1, "end_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
